// File: rtl/cvae_pkg.sv
// Shared constants, FSM state type and segment layout helpers for the CVAE init loader.
package cvae_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] SEG_STATE = 2'd0;
  localparam logic [1:0] SEG_GOAL  = 2'd1;
  localparam logic [1:0] SEG_Z     = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int total_len(input int state_len, input int goal_len, input int z_len);
    return state_len + goal_len + z_len;
  endfunction

  // Burst offset of the first word of a segment; seg 3 maps to the end of the burst.
  function automatic int seg_base(input int seg, input int state_len, input int goal_len,
                                  input int z_len);
    case (seg)
      0:       return 0;
      1:       return state_len;
      2:       return state_len + goal_len;
      default: return total_len(state_len, goal_len, z_len);
    endcase
  endfunction

endpackage

// File: rtl/cvae_reg_bank.sv
// DEPTH x DATA_WIDTH flop bank with indexed write and combinational read.
// Reads outside the bank return zero; out-of-range writes are dropped.
module cvae_reg_bank
  import cvae_pkg::*;
#(
  parameter int DEPTH      = 13,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  // Compare-based mux so an index wider than the bank simply falls through to zero.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_data = r_mem[i];
    end
  end

endmodule

// File: rtl/cvae_init_loader.sv
// Burst loader: after a start pulse, streams init_data words into the state, goal and
// Z banks in order, then pulses done. Random-access read port for the compute datapath.
module cvae_init_loader
  import cvae_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STATE_LEN  = 13,
  parameter int GOAL_LEN   = 6,
  parameter int Z_LEN      = 4,
  parameter int USE_VALID  = 0,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  init_valid,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded,
  output logic                  restart_err,
  output logic [CNT_W-1:0]      word_cnt,
  input  logic [1:0]            rd_seg,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int TOTAL     = total_len(STATE_LEN, GOAL_LEN, Z_LEN);
  localparam int BASE_GOAL = seg_base(1, STATE_LEN, GOAL_LEN, Z_LEN);
  localparam int BASE_Z    = seg_base(2, STATE_LEN, GOAL_LEN, Z_LEN);

  localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_BASE_GOAL = CNT_W'(BASE_GOAL);
  localparam logic [CNT_W-1:0] CNT_BASE_Z    = CNT_W'(BASE_Z);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic               r_loaded, w_loaded_nxt;
  logic               r_restart_err, w_restart_err_nxt;
  logic               w_accept;
  logic               w_capture;
  logic [2:0]         w_wr_en;
  logic [CNT_W-1:0]   w_offset;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [DATA_WIDTH-1:0] w_rd_state, w_rd_goal, w_rd_z;

  assign w_accept = (USE_VALID != 0) ? init_valid : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_word_cnt    <= '0;
      r_loaded      <= 1'b0;
      r_restart_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_loaded      <= w_loaded_nxt;
      r_restart_err <= w_restart_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_word_cnt_nxt    = r_word_cnt;
    w_loaded_nxt      = r_loaded;
    w_restart_err_nxt = 1'b0;
    w_capture         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt    = LOAD;
          w_word_cnt_nxt = '0;
          w_loaded_nxt   = 1'b0;
        end
      end
      LOAD: begin
        // A start here restarts the burst; that cycle's data is never captured.
        if (start) begin
          w_word_cnt_nxt    = '0;
          w_restart_err_nxt = 1'b1;
        end else if (w_accept) begin
          w_capture      = 1'b1;
          w_word_cnt_nxt = r_word_cnt + 1'b1;
          if (r_word_cnt == LAST_CNT) begin
            w_state_nxt  = DONE;
            w_loaded_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          w_state_nxt    = LOAD;
          w_word_cnt_nxt = '0;
          w_loaded_nxt   = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en  = 3'b000;
    w_offset = r_word_cnt;
    if (r_word_cnt < CNT_BASE_GOAL) begin
      w_wr_en[SEG_STATE] = w_capture;
    end else if (r_word_cnt < CNT_BASE_Z) begin
      w_wr_en[SEG_GOAL] = w_capture;
      w_offset          = r_word_cnt - CNT_BASE_GOAL;
    end else begin
      w_wr_en[SEG_Z] = w_capture;
      w_offset       = r_word_cnt - CNT_BASE_Z;
    end
  end

  assign w_wr_idx = IDX_W'(w_offset);

  cvae_reg_bank #(
    .DEPTH     (STATE_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_bank_state (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en[SEG_STATE]),
    .i_wr_idx (w_wr_idx),
    .i_wr_data(init_data),
    .i_rd_idx (rd_idx),
    .o_rd_data(w_rd_state)
  );

  cvae_reg_bank #(
    .DEPTH     (GOAL_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_bank_goal (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en[SEG_GOAL]),
    .i_wr_idx (w_wr_idx),
    .i_wr_data(init_data),
    .i_rd_idx (rd_idx),
    .o_rd_data(w_rd_goal)
  );

  cvae_reg_bank #(
    .DEPTH     (Z_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_bank_z (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en[SEG_Z]),
    .i_wr_idx (w_wr_idx),
    .i_wr_data(init_data),
    .i_rd_idx (rd_idx),
    .o_rd_data(w_rd_z)
  );

  always_comb begin
    case (rd_seg)
      SEG_STATE: rd_data = w_rd_state;
      SEG_GOAL:  rd_data = w_rd_goal;
      SEG_Z:     rd_data = w_rd_z;
      default:   rd_data = '0;
    endcase
  end

  assign busy        = (r_state == LOAD);
  assign done        = (r_state == DONE);
  assign loaded      = r_loaded;
  assign restart_err = r_restart_err;
  assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_cvae_init_loader.sv
// Scoreboard bench for cvae_init_loader: default, valid-gapped and small-segment instances.
module tb_cvae_init_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, start2;
  logic        init_valid;
  logic [31:0] init_data;
  logic [1:0]  rd_seg;
  logic [3:0]  rd_idx;

  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        loaded0, loaded1, loaded2;
  logic        rerr0, rerr1, rerr2;
  logic [4:0]  wcnt0, wcnt1, wcnt2;
  logic [31:0] rd0, rd1, rd2;

  always #5 clk = ~clk;

  cvae_init_loader u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .init_valid(init_valid), .init_data(init_data),
    .busy(busy0), .done(done0), .loaded(loaded0), .restart_err(rerr0), .word_cnt(wcnt0),
    .rd_seg(rd_seg), .rd_idx(rd_idx), .rd_data(rd0)
  );

  cvae_init_loader #(.USE_VALID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .init_valid(init_valid), .init_data(init_data),
    .busy(busy1), .done(done1), .loaded(loaded1), .restart_err(rerr1), .word_cnt(wcnt1),
    .rd_seg(rd_seg), .rd_idx(rd_idx), .rd_data(rd1)
  );

  cvae_init_loader #(.STATE_LEN(2), .GOAL_LEN(1), .Z_LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .init_valid(init_valid), .init_data(init_data),
    .busy(busy2), .done(done2), .loaded(loaded2), .restart_err(rerr2), .word_cnt(wcnt2),
    .rd_seg(rd_seg), .rd_idx(rd_idx), .rd_data(rd2)
  );

  typedef struct {
    logic [1:0]  seg;
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk_exp(input int k, input int sl, input int gl, input logic [31:0] d);
    exp_t e;
    if (k < sl) begin
      e.seg = 2'd0; e.idx = 4'(k);
    end else if (k < sl + gl) begin
      e.seg = 2'd1; e.idx = 4'(k - sl);
    end else begin
      e.seg = 2'd2; e.idx = 4'(k - sl - gl);
    end
    e.data = d;
    return e;
  endfunction

  function automatic logic get_busy(input int w);
    case (w) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic get_done(input int w);
    case (w) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic get_loaded(input int w);
    case (w) 0: return loaded0; 1: return loaded1; default: return loaded2; endcase
  endfunction
  function automatic logic [4:0] get_wcnt(input int w);
    case (w) 0: return wcnt0; 1: return wcnt1; default: return wcnt2; endcase
  endfunction
  function automatic logic [31:0] get_rd(input int w);
    case (w) 0: return rd0; 1: return rd1; default: return rd2; endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w) 0: start0 = v; 1: start1 = v; default: start2 = v; endcase
  endtask

  // Full burst on one instance; words are pushed to the scoreboard as they are driven.
  task automatic run_burst(input int w, input int sl, input int gl, input int zl,
                           input logic [31:0] base, input bit gapped);
    int total, last_edge, k;
    logic v;
    logic [31:0] d;
    total = sl + gl + zl;
    last_edge = gapped ? 2 * total - 1 : total;
    k = 0;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    for (int c = 0; c < last_edge + 3; c++) begin
      v = gapped ? (c % 2 == 0) : 1'b1;
      if (v && k < total) begin
        d = base + 32'(k);
        exp_q.push_back(mk_exp(k, sl, gl, d));
        k++;
      end else begin
        d = 32'hBAD0_0000 + 32'(c);
      end
      init_valid = v;
      init_data  = d;
      @(posedge clk); #1;
      n_vec++;
      if (get_busy(w) !== 1'(c + 1 < last_edge)) begin
        n_err++;
        $display("FAIL busy inst%0d edge %0d: got %b expected %b", w, c + 1, get_busy(w), (c + 1 < last_edge));
      end
      n_vec++;
      if (get_done(w) !== 1'(c + 1 == last_edge)) begin
        n_err++;
        $display("FAIL done inst%0d edge %0d: got %b expected %b", w, c + 1, get_done(w), (c + 1 == last_edge));
      end
      if (c + 1 == last_edge) begin
        n_vec++;
        if (get_wcnt(w) !== 5'(total)) begin
          n_err++;
          $display("FAIL word_cnt_at_done inst%0d: got %0d expected %0d", w, get_wcnt(w), total);
        end
        n_vec++;
        if (get_loaded(w) !== 1'b1) begin
          n_err++;
          $display("FAIL loaded_at_done inst%0d: got %b expected 1", w, get_loaded(w));
        end
      end
    end
    n_vec++;
    if (get_loaded(w) !== 1'b1) begin
      n_err++;
      $display("FAIL loaded_after inst%0d: got %b expected 1", w, get_loaded(w));
    end
  endtask

  task automatic drain(input int w);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd_seg = e.seg;
      rd_idx = e.idx;
      #1;
      n_vec++;
      if (get_rd(w) !== e.data) begin
        n_err++;
        $display("FAIL rd_data inst%0d seg%0d[%0d]: got %h expected %h", w, e.seg, e.idx, get_rd(w), e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 0; start1 = 0; start2 = 0;
    init_valid = 0; init_data = '0; rd_seg = 0; rd_idx = 0;
    #12;
    n_vec++;
    if ({busy0, done0, loaded0, rerr0, wcnt0} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0", {busy0, done0, loaded0, rerr0, wcnt0});
    end
    for (int s = 0; s < 3; s++) begin
      rd_seg = 2'(s); rd_idx = 4'd0; #1;
      n_vec++;
      if (rd0 !== 32'd0) begin
        n_err++;
        $display("FAIL reset_bank seg%0d: got %h expected 0", s, rd0);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_burst(0, 13, 6, 4, 32'h1000, 1'b0);
    drain(0);
  endtask

  task automatic test_gapped();
    run_burst(1, 13, 6, 4, 32'h0000_00A0, 1'b1);
    drain(1);
  endtask

  task automatic test_restart();
    int rerr_cnt, done_cnt;
    rerr_cnt = 0; done_cnt = 0;
    init_valid = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      init_data = 32'hDEAD_0000 + 32'(k);
      @(posedge clk); #1;
    end
    start0 = 1'b1;
    init_data = 32'hDEAD_00FF;
    @(posedge clk); #1;
    start0 = 1'b0;
    n_vec++;
    if (rerr0 !== 1'b1 || wcnt0 !== 5'd0 || busy0 !== 1'b1) begin
      n_err++;
      $display("FAIL restart_entry: got rerr=%b cnt=%0d busy=%b expected 1/0/1", rerr0, wcnt0, busy0);
    end
    for (int c = 0; c < 25; c++) begin
      if (c < 23) begin
        init_data = 32'h2000 + 32'(c);
        exp_q.push_back(mk_exp(c, 13, 6, 32'h2000 + 32'(c)));
      end else begin
        init_data = 32'hBAD1_0000 + 32'(c);
      end
      @(posedge clk); #1;
      if (rerr0) rerr_cnt++;
      if (done0) done_cnt++;
    end
    n_vec++;
    if (rerr_cnt !== 0) begin
      n_err++;
      $display("FAIL restart_err_pulse_width: extra pulses got %0d expected 0", rerr_cnt);
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
    end
    drain(0);
  endtask

  task automatic test_async_reset();
    int done_cnt;
    done_cnt = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      init_data = 32'h7000 + 32'(k);
      @(posedge clk); #1;
    end
    n_vec++;
    if (busy0 !== 1'b1 || wcnt0 !== 5'd10) begin
      n_err++;
      $display("FAIL pre_reset: got busy=%b cnt=%0d expected 1/10", busy0, wcnt0);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy0 !== 1'b0 || wcnt0 !== 5'd0 || loaded0 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b cnt=%0d loaded=%b expected 0/0/0", busy0, wcnt0, loaded0);
    end
    for (int k = 0; k < 10; k++) begin
      rd_seg = 2'd0; rd_idx = 4'(k); #1;
      n_vec++;
      if (rd0 !== 32'd0) begin
        n_err++;
        $display("FAIL async_reset_bank idx%0d: got %h expected 0", k, rd0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done0) done_cnt++;
    end
    n_vec++;
    if (done_cnt !== 0) begin
      n_err++;
      $display("FAIL no_done_after_reset: got %0d pulses expected 0", done_cnt);
    end
    run_burst(0, 13, 6, 4, 32'h3000, 1'b0);
    drain(0);
  endtask

  task automatic test_read_bounds();
    logic [1:0]  segs [7] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [3:0]  idxs [7] = '{4'd6, 4'd0, 4'd3, 4'd13, 4'd15, 4'd5, 4'd5};
    logic [31:0] exps [7] = '{32'd0, 32'd0, 32'h3016, 32'd0, 32'd0, 32'd0, 32'h3012};
    for (int i = 0; i < 7; i++) begin
      rd_seg = segs[i]; rd_idx = idxs[i]; #1;
      n_vec++;
      if (rd0 !== exps[i]) begin
        n_err++;
        $display("FAIL read_bound seg%0d[%0d]: got %h expected %h", segs[i], idxs[i], rd0, exps[i]);
      end
    end
  endtask

  task automatic test_small();
    init_valid = 1'b1;
    run_burst(2, 2, 1, 1, 32'h5000, 1'b0);
    drain(2);
  endtask

  task automatic test_back_to_back();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      init_data = 32'h8000 + 32'(k);
      @(posedge clk); #1;
    end
    n_vec++;
    if (done2 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_done: got %b expected 1", done2);
    end
    start2 = 1'b1;
    init_data = 32'hBAD2_0000;
    @(posedge clk); #1;
    start2 = 1'b0;
    n_vec++;
    if (busy2 !== 1'b1 || loaded2 !== 1'b0 || wcnt2 !== 5'd0 || rerr2 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart_from_done: got busy=%b loaded=%b cnt=%0d rerr=%b expected 1/0/0/0",
               busy2, loaded2, wcnt2, rerr2);
    end
    for (int k = 0; k < 4; k++) begin
      init_data = 32'h6000 + 32'(k);
      exp_q.push_back(mk_exp(k, 2, 1, 32'h6000 + 32'(k)));
      @(posedge clk); #1;
    end
    n_vec++;
    if (done2 !== 1'b1 || loaded2 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_done: got done=%b loaded=%b expected 1/1", done2, loaded2);
    end
    drain(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_restart();
    test_async_reset();
    test_read_bounds();
    test_small();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
